// File: rtl/pwm_sine_modulator.sv
// Sinusoidal PWM: a phase accumulator walks a 256-entry sine ROM that sets the duty of an 8-bit, 255-cycle carrier.
// Define DIFF_CLK_EN to take the clock through an IBUFDS from clk_p/clk_n; otherwise clk_p is used directly.
module pwm_sine_modulator #(
  parameter int unsigned FCLK_HZ = 100_000_000,
  parameter int unsigned F_HI_HZ = 1000,
  parameter int unsigned F_LO_HZ = 500,
  parameter int unsigned ACC_W   = 32
) (
  input  logic clk_p,
  input  logic clk_n,
  input  logic rst_n,
  input  logic sw0,
  output logic pwm
);

  localparam logic [63:0]      INC_HI_FULL = (64'(F_HI_HZ) << ACC_W) / 64'(FCLK_HZ);
  localparam logic [63:0]      INC_LO_FULL = (64'(F_LO_HZ) << ACC_W) / 64'(FCLK_HZ);
  localparam logic [ACC_W-1:0] INC_HI      = INC_HI_FULL[ACC_W-1:0];
  localparam logic [ACC_W-1:0] INC_LO      = INC_LO_FULL[ACC_W-1:0];
  localparam logic [7:0]       CNT_LAST    = 8'd254;
  localparam logic [7:0]       DUTY_MID    = 8'd128;

  logic clk;

`ifdef DIFF_CLK_EN
  IBUFDS u_ibufds (
    .I  (clk_p),
    .IB (clk_n),
    .O  (clk)
  );
`else
  logic unused_clk_n;
  assign clk          = clk_p;
  assign unused_clk_n = clk_n;
`endif

  // First quadrant of round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry.
  function automatic logic [7:0] quarter_sine(input logic [6:0] k);
    logic [7:0] v;
    case (k)
      7'd0:  v = 8'd128;  7'd1:  v = 8'd131;  7'd2:  v = 8'd134;  7'd3:  v = 8'd137;
      7'd4:  v = 8'd140;  7'd5:  v = 8'd143;  7'd6:  v = 8'd146;  7'd7:  v = 8'd149;
      7'd8:  v = 8'd152;  7'd9:  v = 8'd155;  7'd10: v = 8'd158;  7'd11: v = 8'd162;
      7'd12: v = 8'd165;  7'd13: v = 8'd167;  7'd14: v = 8'd170;  7'd15: v = 8'd173;
      7'd16: v = 8'd176;  7'd17: v = 8'd179;  7'd18: v = 8'd182;  7'd19: v = 8'd185;
      7'd20: v = 8'd188;  7'd21: v = 8'd190;  7'd22: v = 8'd193;  7'd23: v = 8'd196;
      7'd24: v = 8'd198;  7'd25: v = 8'd201;  7'd26: v = 8'd203;  7'd27: v = 8'd206;
      7'd28: v = 8'd208;  7'd29: v = 8'd211;  7'd30: v = 8'd213;  7'd31: v = 8'd215;
      7'd32: v = 8'd218;  7'd33: v = 8'd220;  7'd34: v = 8'd222;  7'd35: v = 8'd224;
      7'd36: v = 8'd226;  7'd37: v = 8'd228;  7'd38: v = 8'd230;  7'd39: v = 8'd232;
      7'd40: v = 8'd234;  7'd41: v = 8'd235;  7'd42: v = 8'd237;  7'd43: v = 8'd238;
      7'd44: v = 8'd240;  7'd45: v = 8'd241;  7'd46: v = 8'd243;  7'd47: v = 8'd244;
      7'd48: v = 8'd245;  7'd49: v = 8'd246;  7'd50: v = 8'd248;  7'd51: v = 8'd249;
      7'd52: v = 8'd250;  7'd53: v = 8'd250;  7'd54: v = 8'd251;  7'd55: v = 8'd252;
      7'd56: v = 8'd253;  7'd57: v = 8'd253;  7'd58: v = 8'd254;  7'd59: v = 8'd254;
      7'd60: v = 8'd254;  7'd61: v = 8'd255;  7'd62: v = 8'd255;  7'd63: v = 8'd255;
      7'd64: v = 8'd255;
      default: v = DUTY_MID;
    endcase
    return v;
  endfunction

  logic [1:0]       sw_sync_q, sw_sync_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       duty_q, duty_d;
  logic             pwm_q, pwm_d;

  logic [7:0] lut_idx;
  logic [6:0] lut_fold;
  logic [7:0] lut_quarter;
  logic [7:0] lut_val;

  // NOTE: the sine ROM is pure combinational logic with no state, so it needs no reset.
  always_comb begin
    lut_idx     = acc_q[ACC_W-1 -: 8];
    lut_fold    = (lut_idx[6:0] <= 7'd64) ? lut_idx[6:0] : 7'(8'd128 - {1'b0, lut_idx[6:0]});
    lut_quarter = quarter_sine(lut_fold);
    if (!lut_idx[7]) begin
      lut_val = lut_quarter;
    end else if (lut_idx[6:0] == 7'd0) begin
      lut_val = DUTY_MID;
    end else begin
      lut_val = 8'd255 - lut_quarter;
    end
  end

  // Duty is latched only on the last carrier cycle so a period never changes width mid-way.
  always_comb begin
    sw_sync_d = {sw_sync_q[0], sw0};
    acc_d     = acc_q + (sw_sync_q[1] ? INC_HI : INC_LO);
    cnt_d     = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    duty_d    = (cnt_q == CNT_LAST) ? lut_val : duty_q;
    pwm_d     = (cnt_q < duty_q);
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_sync_q <= 2'b00;
      acc_q     <= '0;
      cnt_q     <= 8'd0;
      duty_q    <= DUTY_MID;
      pwm_q     <= 1'b0;
    end else begin
      sw_sync_q <= sw_sync_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: tb/tb_pwm_sine_modulator.sv
// Scoreboard bench for pwm_sine_modulator: a reference model queues the duty of each carrier period,
// and a monitor measures pwm high time per 255-cycle window and compares it against the queue.
`timescale 1ns/1ps
module tb_pwm_sine_modulator;

  localparam int unsigned FCLK_HZ = 100_000_000;
  localparam int unsigned F_HI_HZ = 1500;
  localparam int unsigned F_LO_HZ = 750;
  localparam int unsigned ACC_W   = 32;
  localparam logic [63:0] INC_HI_FULL = (64'(F_HI_HZ) << ACC_W) / 64'(FCLK_HZ);
  localparam logic [63:0] INC_LO_FULL = (64'(F_LO_HZ) << ACC_W) / 64'(FCLK_HZ);
  localparam logic [31:0] INC_HI = INC_HI_FULL[31:0];
  localparam logic [31:0] INC_LO = INC_LO_FULL[31:0];
  localparam real PI = 3.14159265358979323846;

  logic clk_p = 1'b0;
  logic clk_n;
  logic rst_n = 1'b0;
  logic sw0   = 1'b1;
  logic pwm;

  always #5 clk_p = ~clk_p;
  assign clk_n = ~clk_p;

  pwm_sine_modulator #(
    .FCLK_HZ (FCLK_HZ),
    .F_HI_HZ (F_HI_HZ),
    .F_LO_HZ (F_LO_HZ),
    .ACC_W   (ACC_W)
  ) dut (
    .clk_p (clk_p),
    .clk_n (clk_n),
    .rst_n (rst_n),
    .sw0   (sw0),
    .pwm   (pwm)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_win   = 0;
  int n_max   = 0;
  int n_min   = 0;
  logic [7:0] exp_q[$];

  logic [1:0]  m_sync;
  logic [31:0] m_acc;
  logic [7:0]  m_cnt;
  logic [7:0]  m_duty;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] lut_ref(input logic [7:0] k);
    real v;
    v = 127.5 + 127.5 * $sin(2.0 * PI * real'(k) / 256.0);
    if (v < 0.0) v = 0.0;
    if (v > 255.0) v = 255.0;
    return 8'(int'(v));
  endfunction

  // Reference model: pushes the duty of the upcoming period at each carrier boundary.
  initial begin
    forever begin
      @(posedge clk_p or negedge rst_n);
      if (!rst_n) begin
        m_sync = 2'b00;
        m_acc  = '0;
        m_cnt  = 8'd0;
        m_duty = 8'd128;
        exp_q.delete();
        exp_q.push_back(8'd128);
      end else begin
        if (m_cnt == 8'd254) begin
          m_duty = lut_ref(m_acc[31:24]);
          exp_q.push_back(m_duty);
        end
        m_cnt  = (m_cnt == 8'd254) ? 8'd0 : m_cnt + 8'd1;
        m_acc  = m_acc + (m_sync[1] ? INC_HI : INC_LO);
        m_sync = {m_sync[0], sw0};
      end
    end
  end

  // Monitor: one comparison per completed 255-cycle window; partial windows cut by reset are dropped.
  initial begin
    int pos;
    int hi;
    logic [7:0] e;
    pos = 0;
    hi  = 0;
    forever begin
      @(posedge clk_p);
      if (!rst_n) begin
        pos = 0;
        hi  = 0;
        #1 check("pwm_in_reset", 64'(pwm), 64'd0);
      end else begin
        #1;
        hi  += int'(pwm);
        pos++;
        if (pos == 255) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL period_%0d: high=%0d, no expected duty queued", n_win, hi);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("period_%0d_high_cycles", n_win), 64'(hi), 64'(e));
            if (e == 8'd255) n_max++;
            if (e == 8'd0)   n_min++;
          end
          n_win++;
          pos = 0;
          hi  = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] base;
    logic [31:0] e1, e2, e3;
    logic        found;

    repeat (10) @(posedge clk_p);
    #3 rst_n = 1'b1;

    // Mid-period reset during a high phase, after two full periods.
    repeat (520) @(posedge clk_p);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(posedge clk_p);
      #3;
      if (m_cnt == 8'd100 && m_duty > 8'd100) found = 1'b1;
    end
    check("reset_target_found", 64'(found), 64'd1);
    check("pwm_high_before_reset", 64'(pwm), 64'd1);
    rst_n = 1'b0;
    #1;
    check("pwm_async_reset", 64'(pwm), 64'd0);
    check("cnt_async_reset", 64'(dut.cnt_q), 64'd0);
    check("acc_async_reset", 64'(dut.acc_q), 64'd0);
    repeat (5) @(posedge clk_p);
    #3 rst_n = 1'b1;

    // sw0=1 sweep past indices 64 (duty 255) and 192 (duty 0).
    repeat (51000) @(posedge clk_p);

    // Switch to the low frequency: two more high steps, then low steps.
    #3 sw0 = 1'b0;
    base = m_acc;
    e1 = base + INC_HI;
    e2 = e1 + INC_HI;
    e3 = e2 + INC_LO;
    @(posedge clk_p); #1 check("acc_step1_hi", 64'(dut.acc_q), 64'(e1));
    @(posedge clk_p); #1 check("acc_step2_hi", 64'(dut.acc_q), 64'(e2));
    @(posedge clk_p); #1 check("acc_step3_lo", 64'(dut.acc_q), 64'(e3));
    repeat (1500) @(posedge clk_p);
    #3;

    check("periods_checked", 64'(n_win >= 207), 64'd1);
    check("duty_255_periods_seen", 64'(n_max > 0), 64'd1);
    check("duty_0_periods_seen", 64'(n_min > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_sine_modulator.md
Name: pwm_sine_modulator

Overview:
- Sinusoidal PWM generator for board-level LED/analog output.
- A phase accumulator walks a 256-entry sine table. Each table sample sets the duty cycle of an 8-bit PWM carrier.
- Slide switch sw0 selects one of two modulation frequencies.
- Top-level block: takes the board oscillator (differential or single-ended) and drives one pwm pin.

Parameters:
- FCLK_HZ, 100000000, input clock frequency in Hz.
- F_HI_HZ, 1000, modulation frequency when sw0=1.
- F_LO_HZ, 500, modulation frequency when sw0=0.
- ACC_W, 32, phase accumulator width.

Ports:
- clk_p  input  1  clock, positive leg of the board oscillator; sole clock domain.
- clk_n  input  1  negative leg of the board oscillator; used only with DIFF_CLK_EN.
- rst_n  input  1  asynchronous active-low reset.
- sw0  input  1  frequency select, asynchronous to the clock.
- pwm  output  1  pulse-width-modulated output, registered.

Interface decision (already decided): one clock; reset is asynchronous and active-low (clk_p / rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, acc=0, duty_q=128, sw_sync=2'b00, pwm=0.
  - Release is sampled on the next clk_p rising edge.
- sw0 synchronizer: 2-FF synchronizer; sw_s = sw_sync[1], so sw0 changes take effect 2 cycles later.
- Increments, computed at elaboration with integer truncation:
  - INC_HI = F_HI_HZ*2^ACC_W/FCLK_HZ = 42949 at defaults.
  - INC_LO = F_LO_HZ*2^ACC_W/FCLK_HZ = 21474 at defaults.
- Accumulator:
  - Every cycle: acc <= acc + (sw_s ? INC_HI : INC_LO), modulo 2^ACC_W.
  - Phase is continuous across sw0 changes; the accumulator is never cleared except by reset.
- Sine LUT:
  - Index = acc[ACC_W-1:ACC_W-8].
  - Entry k = round(127.5 + 127.5*sin(2*pi*k/256)), clamped 0..255.
  - LUT[0]=128, LUT[64]=255, LUT[128]=128, LUT[192]=0.
  - Combinational ROM; no reset.
- Carrier:
  - cnt counts 0..254 and wraps to 0, giving a 255-cycle period (392.16 kHz at defaults).
  - When cnt==254: duty_q <= LUT[index]. Duty changes only at period boundaries, so no mid-period glitches.
- Output:
  - pwm <= (cnt < duty_q), registered, with 1 cycle of latency from cnt.
  - duty 0: pwm constantly 0.
  - duty 255: pwm constantly 1 (255 of 255 cycles).
  - duty d: exactly d high cycles per period, contiguous, starting one cycle after cnt==0.
- Simultaneous events:
  - An sw0 change and a period boundary in the same cycle: the boundary uses the acc value present at that edge.
  - Reset asserted mid-period forces pwm=0 immediately. The first period after reset uses duty 128.
- Modulation frequency = INC*FCLK_HZ/2^ACC_W. The sample rate is the carrier rate, so each modulation period spans roughly 392 carrier periods at F_HI_HZ.

Optional Feature:
- DIFF_CLK_EN defined:
  - clk_p/clk_n drive a vendor differential input buffer (IBUFDS).
  - Its output is the internal clock.
- DIFF_CLK_EN undefined:
  - clk_p is used directly as the clock; clk_n is left unconnected internally.
  - Intended for single-ended boards such as Zedboard.
- Port list is identical in both builds.

Test Plan:
- Reset check: rst_n=0 for 10 cycles, then release.
  - pwm=0 throughout reset.
  - First carrier period: pwm high exactly 128 cycles, then low 127 cycles.
- Duty tracking at sw0=1: hold sw0 for 2 ms and measure high-time per 255-cycle period.
  - Each period equals LUT[acc index sampled at the cnt==254 boundary].
  - Maximum 255 (pwm solid high) occurs about 0.25 ms after reset; minimum 0 occurs about 0.75 ms after reset.
  - Modulation period is 1.000 ms ±0.1%.
- Frequency switch: sw0 1→0 at 25 ms.
  - acc step becomes 21474 exactly 2 cycles after the sw0 edge.
  - No phase discontinuity: acc is unchanged across the switch except for the new step size.
  - Modulation period becomes 2.000 ms.
- Boundary duties: force acc so the index is 64, then 192.
  - Index 64: pwm constantly 1 for the full period.
  - Index 192: pwm constantly 0 for the full period.
- Mid-period reset: assert rst_n at cnt=100 during a high phase.
  - pwm drops to 0 within the same cycle without waiting for a clock edge; cnt=0 and acc=0.
- Build both with and without DIFF_CLK_EN, driving complementary clk_p/clk_n at 100 MHz.
  - Identical pwm waveforms in both builds.
